// File: rtl/ft_rx_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : ft_rx_reader_if
// Purpose  : Bridge read bus plus local word stream between reader and consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface ft_rx_reader_if;
  logic        rxf_n;
  logic [31:0] data_in;
  logic [3:0]  be_in;
  logic        oe_n;
  logic        rd_n;
  logic [31:0] m_data;
  logic [3:0]  m_be;
  logic        m_valid;
  logic        m_ready;
  logic        overflow;

  modport master (
    input  rxf_n, data_in, be_in, m_ready,
    output oe_n, rd_n, m_data, m_be, m_valid, overflow
  );

  modport slave (
    output rxf_n, data_in, be_in, m_ready,
    input  oe_n, rd_n, m_data, m_be, m_valid, overflow
  );
endinterface
`default_nettype wire

// File: rtl/ft_rx_reader.sv
`default_nettype none
// ============================================================================
// Module   : ft_rx_reader
// Purpose  : Reads words from a USB FIFO bridge into a circular buffer.
//            Optional macro FT_RX_BE_FILTER_EN drops words with partial be_in.
// Revision : 1.0 - initial release
// ============================================================================
module ft_rx_reader #(
  parameter int DEPTH     = 8,
  parameter int FREE_MIN  = 3,
  parameter int STOP_FILL = DEPTH - 2
) (
  input  wire            CLK,
  input  wire            rst_n,
  ft_rx_reader_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;

  localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
  localparam logic [CW-1:0] C_FREE_MIN  = CW'(FREE_MIN);
  localparam logic [CW-1:0] C_STOP_FILL = CW'(STOP_FILL);
  localparam logic [AW:0]   C_PTR_ONE   = (AW+1)'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TURN = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          oe_n_q, oe_n_d;
  logic          rd_n_q, rd_n_d;
  logic          armed_q;
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [35:0]   mem_q [DEPTH];
  logic          overflow_q;

  logic          w_capture, w_push, w_pop, w_wr_en;
  logic          w_full, w_empty;
  logic [CW-1:0] w_fill, w_fill_post, w_free;
  logic [AW-1:0] w_wr_idx, w_rd_idx;

  assign w_wr_idx = wr_ptr_q[AW-1:0];
  assign w_rd_idx = rd_ptr_q[AW-1:0];
  assign w_empty  = (wr_ptr_q == rd_ptr_q);
  assign w_full   = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});

  assign w_capture = ~rd_n_q & ~bus.rxf_n;
`ifdef FT_RX_BE_FILTER_EN
  assign w_push = w_capture & (bus.be_in == 4'hF);
`else
  assign w_push = w_capture;
`endif
  assign w_pop   = ~w_empty & bus.m_ready;
  // A full buffer still accepts a word when the head leaves on the same edge.
  assign w_wr_en = w_push & (~w_full | w_pop);

  assign w_fill      = {1'b0, wr_ptr_q - rd_ptr_q};
  assign w_fill_post = w_fill + CW'(w_wr_en) - CW'(w_pop);
  assign w_free      = C_DEPTH - w_fill;

  always_comb begin
    state_d = state_q;
    oe_n_d  = 1'b1;
    rd_n_d  = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (armed_q && !bus.rxf_n && (w_free >= C_FREE_MIN)) begin
          state_d = S_TURN;
          oe_n_d  = 1'b0;
        end
      end
      S_TURN: begin
        state_d = S_READ;
        oe_n_d  = 1'b0;
        rd_n_d  = 1'b0;
      end
      S_READ: begin
        if (bus.rxf_n || (w_fill_post >= C_STOP_FILL)) begin
          state_d = S_STOP;
        end else begin
          oe_n_d  = 1'b0;
          rd_n_d  = 1'b0;
        end
      end
      S_STOP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // armed_q holds the FSM in IDLE for the first edge after reset release.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      oe_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      oe_n_q  <= oe_n_d;
      rd_n_q  <= rd_n_d;
      armed_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_wr_en) begin
        wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
      end
      if (w_push && w_full && !w_pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_wr_en) begin
      mem_q[w_wr_idx] <= {bus.be_in, bus.data_in};
    end
  end

  assign bus.oe_n     = oe_n_q;
  assign bus.rd_n     = rd_n_q;
  assign bus.m_data   = mem_q[w_rd_idx][31:0];
  assign bus.m_be     = mem_q[w_rd_idx][35:32];
  assign bus.m_valid  = ~w_empty;
  assign bus.overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ft_rx_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft_rx_reader
// Purpose  : Directed self-checking bench for ft_rx_reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ft_rx_reader;

  logic CLK = 1'b0;
  logic rst_n;
  always #5 CLK = ~CLK;

  ft_rx_reader_if bus ();
  ft_rx_reader_if hbus ();

  ft_rx_reader #(.DEPTH(8)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Throttling disabled so the buffer can be driven past full.
  ft_rx_reader #(.DEPTH(8), .FREE_MIN(0), .STOP_FILL(9)) dut_hook (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (hbus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          src_idx, src_count, gap_left, cyc, turns;
  bit          gap_mode;
  logic [31:0] src_base;
  logic [3:0]  src_be [16];
  logic [31:0] got_d [$];
  logic [3:0]  got_be [$];
  int          first_oe, first_rd, first_cap, first_valid;

  task automatic drive_src();
    bus.data_in = src_base + 32'(src_idx);
    bus.be_in   = src_be[src_idx % 16];
    bus.rxf_n   = (src_idx >= src_count) || (gap_left > 0);
  endtask

  task automatic reset_dut();
    @(negedge CLK);
    rst_n = 1'b0;
    src_idx = 0; src_count = 0; gap_left = 0; gap_mode = 1'b0;
    cyc = 0; turns = 0; src_base = '0;
    first_oe = -1; first_rd = -1; first_cap = -1; first_valid = -1;
    for (int i = 0; i < 16; i++) src_be[i] = 4'hF;
    got_d.delete(); got_be.delete();
    bus.m_ready  = 1'b0;
    hbus.rxf_n   = 1'b1;
    hbus.m_ready = 1'b0;
    hbus.data_in = '0;
    hbus.be_in   = 4'hF;
    drive_src();
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
  endtask

  // One clock of bridge source plus consumer; called at a falling edge.
  task automatic step();
    bit cap, pop;
    cap = !bus.rd_n && !bus.rxf_n;
    pop = bus.m_valid && bus.m_ready;
    if (!bus.oe_n && bus.rd_n) turns++;
    if (!bus.oe_n && first_oe < 0) first_oe = cyc;
    if (!bus.rd_n && first_rd < 0) first_rd = cyc;
    if (bus.m_valid && first_valid < 0) first_valid = cyc;
    if (cap && first_cap < 0) first_cap = cyc;
    if (pop) begin
      got_d.push_back(bus.m_data);
      got_be.push_back(bus.m_be);
    end
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
    if (cap) begin
      src_idx++;
      if (gap_mode && (src_idx % 3 == 0)) gap_left = 2;
    end else if (gap_left > 0) begin
      gap_left--;
    end
    drive_src();
  endtask

  task automatic test_reset();
    @(negedge CLK);
    rst_n = 1'b0;
    bus.rxf_n = 1'b1;
    bus.m_ready = 1'b0;
    @(negedge CLK);
    n_checks++; if (bus.oe_n !== 1'b1) begin n_fail++; $display("FAIL rst_oe_n: got %b expected 1", bus.oe_n); end
    n_checks++; if (bus.rd_n !== 1'b1) begin n_fail++; $display("FAIL rst_rd_n: got %b expected 1", bus.rd_n); end
    n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b expected 0", bus.m_valid); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b expected 0", bus.overflow); end
    n_checks++; if (bus.m_data !== 32'h0) begin n_fail++; $display("FAIL rst_m_data: got %h expected 0", bus.m_data); end
    n_checks++; if (bus.m_be !== 4'h0) begin n_fail++; $display("FAIL rst_m_be: got %h expected 0", bus.m_be); end
    bus.rxf_n = 1'b0;
    bus.data_in = '0;
    bus.be_in = 4'hF;
    @(negedge CLK);
    rst_n = 1'b1;
    @(posedge CLK); #1;
    n_checks++; if (bus.oe_n !== 1'b1) begin n_fail++; $display("FAIL rst_first_edge_oe_n: got %b expected 1", bus.oe_n); end
    @(posedge CLK); #1;
    n_checks++; if (bus.oe_n !== 1'b0) begin n_fail++; $display("FAIL rst_second_edge_oe_n: got %b expected 0", bus.oe_n); end
    bus.rxf_n = 1'b1;
  endtask

  task automatic test_basic();
    reset_dut();
    src_base = 32'h100; src_count = 5; bus.m_ready = 1'b1; drive_src();
    for (int i = 0; i < 40 && got_d.size() < 5; i++) step();
    n_checks++; if (got_d.size() !== 5) begin n_fail++; $display("FAIL basic_count: got %0d expected 5", got_d.size()); end
    for (int i = 0; i < got_d.size(); i++) begin
      n_checks++;
      if (got_d[i] !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL basic_word%0d: got %h expected %h", i, got_d[i], 32'h100 + 32'(i)); end
    end
    n_checks++; if (first_oe !== 2) begin n_fail++; $display("FAIL basic_first_oe_cycle: got %0d expected 2", first_oe); end
    n_checks++; if (first_rd - first_oe !== 1) begin n_fail++; $display("FAIL basic_oe_to_rd: got %0d expected 1", first_rd - first_oe); end
    n_checks++; if (first_cap !== 3) begin n_fail++; $display("FAIL basic_first_capture_cycle: got %0d expected 3", first_cap); end
    n_checks++; if (first_valid !== first_cap + 1) begin n_fail++; $display("FAIL basic_m_valid_cycle: got %0d expected %0d", first_valid, first_cap + 1); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_throttle();
    reset_dut();
    src_base = 32'h300; src_count = 20; drive_src();
    repeat (30) step();
    n_checks++; if (src_idx !== 6) begin n_fail++; $display("FAIL throttle_held: got %0d expected 6", src_idx); end
    n_checks++; if (bus.rd_n !== 1'b1) begin n_fail++; $display("FAIL throttle_rd_n: got %b expected 1", bus.rd_n); end
    n_checks++; if (bus.oe_n !== 1'b1) begin n_fail++; $display("FAIL throttle_oe_n: got %b expected 1", bus.oe_n); end
    n_checks++; if (bus.m_data !== 32'h300) begin n_fail++; $display("FAIL throttle_head: got %h expected 300", bus.m_data); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL throttle_overflow: got %b expected 0", bus.overflow); end
    bus.m_ready = 1'b1;
    for (int i = 0; i < 200 && got_d.size() < 20; i++) step();
    n_checks++; if (got_d.size() !== 20) begin n_fail++; $display("FAIL throttle_count: got %0d expected 20", got_d.size()); end
    for (int i = 0; i < got_d.size(); i++) begin
      n_checks++;
      if (got_d[i] !== 32'h300 + 32'(i)) begin n_fail++; $display("FAIL throttle_word%0d: got %h expected %h", i, got_d[i], 32'h300 + 32'(i)); end
    end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL throttle_overflow_end: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_gaps();
    reset_dut();
    src_base = 32'h400; src_count = 9; gap_mode = 1'b1; bus.m_ready = 1'b1; drive_src();
    for (int i = 0; i < 120 && got_d.size() < 9; i++) step();
    repeat (6) step();
    n_checks++; if (got_d.size() !== 9) begin n_fail++; $display("FAIL gaps_count: got %0d expected 9", got_d.size()); end
    for (int i = 0; i < got_d.size(); i++) begin
      n_checks++;
      if (got_d[i] !== 32'h400 + 32'(i)) begin n_fail++; $display("FAIL gaps_word%0d: got %h expected %h", i, got_d[i], 32'h400 + 32'(i)); end
    end
    n_checks++; if (turns !== 3) begin n_fail++; $display("FAIL gaps_turns: got %0d expected 3", turns); end
  endtask

  task automatic test_rxf_at_read();
    reset_dut();
    src_base = 32'h500; src_count = 1; drive_src();
    for (int i = 0; i < 10 && bus.oe_n; i++) step();
    src_count = 0; drive_src();
    step();
    n_checks++; if (bus.rd_n !== 1'b0) begin n_fail++; $display("FAIL late_rxf_read: got rd_n %b expected 0", bus.rd_n); end
    step();
    n_checks++; if (bus.rd_n !== 1'b1 || bus.oe_n !== 1'b1) begin n_fail++; $display("FAIL late_rxf_stop: got oe_n %b rd_n %b expected 1 1", bus.oe_n, bus.rd_n); end
    n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL late_rxf_no_capture: got m_valid %b expected 0", bus.m_valid); end
  endtask

  task automatic test_reset_mid_read();
    reset_dut();
    src_base = 32'h600; src_count = 20; drive_src();
    for (int i = 0; i < 20 && src_idx < 2; i++) step();
    n_checks++; if (bus.rd_n !== 1'b0) begin n_fail++; $display("FAIL midrst_in_read: got rd_n %b expected 0", bus.rd_n); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.oe_n !== 1'b1 || bus.rd_n !== 1'b1) begin n_fail++; $display("FAIL midrst_release: got oe_n %b rd_n %b expected 1 1", bus.oe_n, bus.rd_n); end
    n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_m_valid: got %b expected 0", bus.m_valid); end
    @(negedge CLK);
    src_idx = 0; src_base = 32'h700; src_count = 3; bus.m_ready = 1'b1; drive_src();
    @(negedge CLK);
    rst_n = 1'b1;
    for (int i = 0; i < 40 && got_d.size() < 3; i++) step();
    n_checks++; if (got_d.size() !== 3) begin n_fail++; $display("FAIL midrst_recover_count: got %0d expected 3", got_d.size()); end
    for (int i = 0; i < got_d.size(); i++) begin
      n_checks++;
      if (got_d[i] !== 32'h700 + 32'(i)) begin n_fail++; $display("FAIL midrst_word%0d: got %h expected %h", i, got_d[i], 32'h700 + 32'(i)); end
    end
  endtask

  task automatic test_be();
    int          j;
    int          exp_n;
    logic [3:0]  eb;
    reset_dut();
    src_base = 32'h800; src_count = 5; src_be[2] = 4'h3; bus.m_ready = 1'b1; drive_src();
    repeat (40) step();
`ifdef FT_RX_BE_FILTER_EN
    exp_n = 4;
`else
    exp_n = 5;
`endif
    n_checks++; if (got_d.size() !== exp_n) begin n_fail++; $display("FAIL be_count: got %0d expected %0d", got_d.size(), exp_n); end
    j = 0;
    for (int k = 0; k < 5; k++) begin
      eb = (k == 2) ? 4'h3 : 4'hF;
`ifdef FT_RX_BE_FILTER_EN
      if (k == 2) continue;
`endif
      if (j < got_d.size()) begin
        n_checks++;
        if (got_d[j] !== 32'h800 + 32'(k)) begin n_fail++; $display("FAIL be_word%0d: got %h expected %h", j, got_d[j], 32'h800 + 32'(k)); end
        n_checks++;
        if (got_be[j] !== eb) begin n_fail++; $display("FAIL be_mask%0d: got %h expected %h", j, got_be[j], eb); end
      end
      j++;
    end
  endtask

  task automatic test_overflow();
    int          k;
    int          n;
    bit          c;
    logic [31:0] rd [$];
    reset_dut();
    k = 0;
    hbus.rxf_n = 1'b0;
    hbus.data_in = 32'h900;
    for (int i = 0; i < 20; i++) begin
      c = !hbus.rd_n && !hbus.rxf_n;
      @(posedge CLK);
      @(negedge CLK);
      if (c) k++;
      hbus.data_in = 32'h900 + 32'(k);
    end
    n_checks++; if (k <= 8) begin n_fail++; $display("FAIL ovf_pushes: got %0d expected more than 8", k); end
    n_checks++; if (hbus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", hbus.overflow); end
    n_checks++; if (hbus.m_data !== 32'h900) begin n_fail++; $display("FAIL ovf_head: got %h expected 900", hbus.m_data); end
    hbus.rxf_n = 1'b1;
    repeat (5) @(negedge CLK);
    n_checks++; if (hbus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", hbus.overflow); end
    hbus.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (hbus.m_valid) rd.push_back(hbus.m_data);
      @(posedge CLK);
      @(negedge CLK);
    end
    n = rd.size();
    n_checks++; if (n !== 8) begin n_fail++; $display("FAIL ovf_drain_count: got %0d expected 8", n); end
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (rd[i] !== 32'h900 + 32'(i)) begin n_fail++; $display("FAIL ovf_word%0d: got %h expected %h", i, rd[i], 32'h900 + 32'(i)); end
    end
    n_checks++; if (hbus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky_drained: got %b expected 1", hbus.overflow); end
    reset_dut();
    n_checks++; if (hbus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %b expected 0", hbus.overflow); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.rxf_n = 1'b1; bus.data_in = '0; bus.be_in = 4'hF; bus.m_ready = 1'b0;
    hbus.rxf_n = 1'b1; hbus.data_in = '0; hbus.be_in = 4'hF; hbus.m_ready = 1'b0;
    for (int i = 0; i < 16; i++) src_be[i] = 4'hF;
    test_reset();
    test_basic();
    test_throttle();
    test_gaps();
    test_rxf_at_read();
    test_reset_mid_read();
    test_be();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ft_rx_reader.md
FT_RX_READER -- requirements
Module: ft_rx_reader

Interface
REQ-001 CLK  input  1  single clock for all logic; the USB FIFO interface clock, rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 rxf_n  input  1  FIFO-not-empty from the USB bridge, active low; host data is available.
REQ-004 data_in  input  32  read data from the USB bridge.
REQ-005 be_in  input  4  byte enables accompanying data_in.
REQ-006 oe_n  output  1  bus output-enable to the bridge, active low.
REQ-007 rd_n  output  1  read strobe to the bridge, active low.
REQ-008 m_data  output  32  head word of the local buffer.
REQ-009 m_be  output  4  byte enables of the head word.
REQ-010 m_valid  output  1  buffer non-empty; m_data/m_be valid.
REQ-011 m_ready  input  1  consumer accepts the head word when m_valid and m_ready are high at a rising edge.
REQ-012 overflow  output  1  sticky; a word was captured while the buffer was full.
REQ-013 DEPTH  parameter, default 8  buffer entries; power of two, minimum 4.

Function
REQ-014 FSM states: IDLE, TURN, READ, STOP; all state, oe_n and rd_n are registered.
REQ-015 IDLE -> TURN when rxf_n=0 and free entries >= 3; outputs oe_n=1, rd_n=1 in IDLE.
REQ-016 TURN lasts exactly one cycle with oe_n=0, rd_n=1 (bus turnaround), then -> READ.
REQ-017 READ drives oe_n=0, rd_n=0.
REQ-018 A word is captured at every rising edge where registered rd_n=0 and rxf_n=0; capture writes {be_in,data_in} into the buffer with zero added latency.
REQ-019 READ -> STOP at the edge where rxf_n=1 is sampled, or where the post-edge fill count reaches >= DEPTH-2.
REQ-020 STOP drives oe_n=1, rd_n=1 for one cycle, then -> IDLE; no word is captured in STOP.
REQ-021 With back-to-back data, throughput is one word per CLK in READ; the first word is captured 2 edges after the IDLE -> TURN edge.
REQ-022 Buffer is a circular FIFO with wrap-around pointers of width log2(DEPTH)+1; empty when pointers equal, full when only the MSB differs.
REQ-023 m_valid is asserted the edge after the first word is written into an empty buffer; pop and push in the same cycle leave the fill count unchanged.
REQ-024 Push into a full buffer (not accompanied by a pop) discards the word and sets overflow until reset; the buffer contents are unchanged.
REQ-025 rxf_n rising in the same cycle that rd_n falls: no capture occurs, and the FSM goes READ -> STOP.
REQ-026 m_valid=0 with m_ready=1 has no effect.

Reset
REQ-027 When rst_n=0: state=IDLE, oe_n=1, rd_n=1, pointers=0, m_valid=0, overflow=0, m_data=0, m_be=0, all applied asynchronously.
REQ-028 Reset asserted mid-READ releases oe_n/rd_n immediately, without waiting for an edge, and buffered words are lost.
REQ-029 After rst_n deasserts, the first transition out of IDLE occurs no earlier than the second rising edge.

Configuration
REQ-030 Macro FT_RX_BE_FILTER_EN defined: a captured word with be_in != 4'hF is not written into the buffer, and words with be_in=4'hF behave normally.
REQ-031 FT_RX_BE_FILTER_EN undefined: every captured word is written, and m_be reflects the word's be_in.

Verification
REQ-032 Reset, then rxf_n=0 for 5 words 0x100..0x104 with be=F and m_ready=1 -> oe_n low one cycle before rd_n; m_data delivers 0x100..0x104 in order; overflow=0.
REQ-033 m_ready=0, continuous rxf_n=0, DEPTH=8 -> rd_n deasserts once fill reaches 6; at most 7 words are held; overflow stays 0.
REQ-034 rxf_n toggles 1 after every 3 words -> FSM cycles READ-STOP-IDLE-TURN; no word is duplicated or lost.
REQ-035 rst_n pulsed low mid-READ -> oe_n=1 and rd_n=1 within the same cycle; m_valid=0; recovery on the next rxf_n=0.
REQ-036 Word with be_in=4'h3 amid full-width words -> dropped with FT_RX_BE_FILTER_EN defined; delivered with m_be=3 without it.
REQ-037 Forced push with the buffer full (via a test hook on the free-entry threshold) -> overflow=1, sticky until reset.
